// File: rtl/ysyx_25020037_axi_arbiter.sv
// Two-master, one-slave AXI4 arbiter: IFU (read-only) and LSU (read/write) share one SoC port.
// One whole transaction is granted at a time, round-robin between the two masters.
module ysyx_25020037_axi_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   // IFU read channels
   input  logic        m0_arvalid,
   input  logic [31:0] m0_araddr,
   input  logic [3:0]  m0_arid,
   input  logic [7:0]  m0_arlen,
   input  logic [2:0]  m0_arsize,
   input  logic [1:0]  m0_arburst,
   output logic        m0_arready,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic [1:0]  m0_rresp,
   output logic        m0_rlast,
   output logic [3:0]  m0_rid,
   input  logic        m0_rready,
   // LSU read channels
   input  logic        m1_arvalid,
   input  logic [31:0] m1_araddr,
   input  logic [3:0]  m1_arid,
   input  logic [7:0]  m1_arlen,
   input  logic [2:0]  m1_arsize,
   input  logic [1:0]  m1_arburst,
   output logic        m1_arready,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic [1:0]  m1_rresp,
   output logic        m1_rlast,
   output logic [3:0]  m1_rid,
   input  logic        m1_rready,
   // LSU write channels
   input  logic        m1_awvalid,
   input  logic [31:0] m1_awaddr,
   input  logic [3:0]  m1_awid,
   input  logic [7:0]  m1_awlen,
   input  logic [2:0]  m1_awsize,
   input  logic [1:0]  m1_awburst,
   output logic        m1_awready,
   input  logic        m1_wvalid,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   input  logic        m1_wlast,
   output logic        m1_wready,
   output logic        m1_bvalid,
   output logic [1:0]  m1_bresp,
   output logic [3:0]  m1_bid,
   input  logic        m1_bready,
   // Slave side
   output logic        s_arvalid,
   output logic [31:0] s_araddr,
   output logic [3:0]  s_arid,
   output logic [7:0]  s_arlen,
   output logic [2:0]  s_arsize,
   output logic [1:0]  s_arburst,
   input  logic        s_arready,
   input  logic        s_rvalid,
   input  logic [31:0] s_rdata,
   input  logic [1:0]  s_rresp,
   input  logic        s_rlast,
   input  logic [3:0]  s_rid,
   output logic        s_rready,
   output logic        s_awvalid,
   output logic [31:0] s_awaddr,
   output logic [3:0]  s_awid,
   output logic [7:0]  s_awlen,
   output logic [2:0]  s_awsize,
   output logic [1:0]  s_awburst,
   input  logic        s_awready,
   output logic        s_wvalid,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   output logic        s_wlast,
   input  logic        s_wready,
   input  logic        s_bvalid,
   input  logic [1:0]  s_bresp,
   input  logic [3:0]  s_bid,
   output logic        s_bready
);

   typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

   state_t state, next_state;
   logic   last_grant;
   logic   addr_done;
   logic   req0, req1;

   assign req0 = m0_arvalid;
   assign req1 = m1_awvalid | m1_arvalid;

   // last_grant starts at 1 so the IFU wins the first tie after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         addr_done  <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE) begin
            addr_done <= 1'b0;
            if (next_state == RD0)
               last_grant <= 1'b0;
            else if (next_state != IDLE)
               last_grant <= 1'b1;
         end else if ((s_arvalid && s_arready) || (s_awvalid && s_awready)) begin
            addr_done <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || last_grant))
               next_state = RD0;
            else if (req1)
               next_state = m1_awvalid ? WR1 : RD1;
         end
         RD0, RD1: begin
            if (s_rvalid && s_rready && s_rlast)
               next_state = IDLE;
         end
         WR1: begin
            if (s_bvalid && s_bready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Address readys are gated with addr_done too, so a master queuing its next
   // request during the data phase is not told it was accepted.
   always_comb begin
      m0_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = 32'h0;
      m0_rresp   = 2'b00;
      m0_rlast   = 1'b0;
      m0_rid     = 4'h0;
      m1_arready = 1'b0;
      m1_rvalid  = 1'b0;
      m1_rdata   = 32'h0;
      m1_rresp   = 2'b00;
      m1_rlast   = 1'b0;
      m1_rid     = 4'h0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bvalid  = 1'b0;
      m1_bresp   = 2'b00;
      m1_bid     = 4'h0;
      s_arvalid  = 1'b0;
      s_araddr   = 32'h0;
      s_arid     = 4'h0;
      s_arlen    = 8'h0;
      s_arsize   = 3'h0;
      s_arburst  = 2'h0;
      s_rready   = 1'b0;
      s_awvalid  = 1'b0;
      s_awaddr   = 32'h0;
      s_awid     = 4'h0;
      s_awlen    = 8'h0;
      s_awsize   = 3'h0;
      s_awburst  = 2'h0;
      s_wvalid   = 1'b0;
      s_wdata    = 32'h0;
      s_wstrb    = 4'h0;
      s_wlast    = 1'b0;
      s_bready   = 1'b0;
      case (state)
         RD0: begin
            s_arvalid  = m0_arvalid & ~addr_done;
            s_araddr   = m0_araddr;
            s_arid     = m0_arid;
            s_arlen    = m0_arlen;
            s_arsize   = m0_arsize;
            s_arburst  = m0_arburst;
            m0_arready = s_arready & ~addr_done;
            m0_rvalid  = s_rvalid;
            m0_rdata   = s_rdata;
            m0_rresp   = s_rresp;
            m0_rlast   = s_rlast;
            m0_rid     = s_rid;
            s_rready   = m0_rready;
         end
         RD1: begin
            s_arvalid  = m1_arvalid & ~addr_done;
            s_araddr   = m1_araddr;
            s_arid     = m1_arid;
            s_arlen    = m1_arlen;
            s_arsize   = m1_arsize;
            s_arburst  = m1_arburst;
            m1_arready = s_arready & ~addr_done;
            m1_rvalid  = s_rvalid;
            m1_rdata   = s_rdata;
            m1_rresp   = s_rresp;
            m1_rlast   = s_rlast;
            m1_rid     = s_rid;
            s_rready   = m1_rready;
         end
         WR1: begin
            s_awvalid  = m1_awvalid & ~addr_done;
            s_awaddr   = m1_awaddr;
            s_awid     = m1_awid;
            s_awlen    = m1_awlen;
            s_awsize   = m1_awsize;
            s_awburst  = m1_awburst;
            m1_awready = s_awready & ~addr_done;
            s_wvalid   = m1_wvalid;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            s_wlast    = m1_wlast;
            m1_wready  = s_wready;
            m1_bvalid  = s_bvalid;
            m1_bresp   = s_bresp;
            m1_bid     = s_bid;
            s_bready   = m1_bready;
         end
         default: ;
      endcase
   end

endmodule
